logic_unit_pipe: RTL

//  Parametrised, pipelined bitwise logic unit: next generation of the fixed 32-bit XOR array.

---
 rtl/logic_unit_pipe.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe
//   Two-stage pipelined bitwise logic unit with an optional XOR accumulator.
//   Stage 1 registers the operation and operands. Stage 2 registers the
//   result and its zero/parity flags. Both sides use a valid/ready handshake,
//   and the unit sustains one beat per cycle when downstream is ready.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 2)
//   ACC_EN  1: op 3'b110 is XOR-accumulate; 0: op 3'b110 is plain XOR
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  unit accepts the beat this cycle
//   op         in   operation select, sampled with the beat
//   a, b       in   operands
//   acc_clr    in   synchronous accumulator clear
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   result     out  registered result
//   zero       out  result == 0
//   parity     out  XOR-reduction of result
// ---------------------------------------------------------------------------
module logic_unit_pipe #(
    parameter int WIDTH  = 32,
    parameter bit ACC_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);

    typedef enum logic [2:0] {
        OP_AND    = 3'b000,
        OP_OR     = 3'b001,
        OP_XOR    = 3'b010,
        OP_NOR    = 3'b011,
        OP_XNOR   = 3'b100,
        OP_NAND   = 3'b101,
        OP_ACCXOR = 3'b110,
        OP_PASSA  = 3'b111
    } op_e;

    // Stage 1 state
    logic             s1_valid;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    // Handshake
    logic accept;
    logic adv2;

    // Accumulator view seen by the stage-1 -> stage-2 transfer
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_base;

    logic [WIDTH-1:0] res_c;

    // S1 drains when S2 is empty or S2 is being consumed this cycle, so
    // in_ready can stay high on a full S1 without inserting a bubble.
    assign adv2     = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || adv2;
    assign accept   = in_valid && in_ready;

    // NOTE: operand/op flops carry no reset; they are only observed when
    // s1_valid is set, so resetting them would add routing for no benefit.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op <= op_e'(op);
            s1_a  <= a;
            s1_b  <= b;
        end
    end

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    // NOTE: combinational blocks assign a default first so no path leaves
    // res_c unassigned and no latch is inferred.
    always_comb begin
        res_c = '0;
        unique case (s1_op)
            OP_AND:    res_c = s1_a & s1_b;
            OP_OR:     res_c = s1_a | s1_b;
            OP_XOR:    res_c = s1_a ^ s1_b;
            OP_NOR:    res_c = ~(s1_a | s1_b);
            OP_XNOR:   res_c = ~(s1_a ^ s1_b);
            OP_NAND:   res_c = ~(s1_a & s1_b);
            OP_ACCXOR: res_c = acc_base ^ s1_a ^ s1_b;
            OP_PASSA:  res_c = s1_a;
            default:   res_c = '0;
        endcase
    end

    generate
        if (ACC_EN) begin : g_acc
            // A clear on the same edge as an advancing ACCXOR beat takes
            // effect first, so that beat starts from zero.
            assign acc_base = acc_clr ? '0 : acc_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q <= '0;
                end else if (adv2 && (s1_op == OP_ACCXOR)) begin
                    acc_q <= res_c;
                end else if (acc_clr) begin
                    acc_q <= '0;
                end
            end
        end else begin : g_no_acc
            // No accumulator: op 110 degenerates to a ^ b, acc_clr has no effect.
            logic unused_acc_clr;
            assign unused_acc_clr = acc_clr;
            assign acc_q          = '0;
            assign acc_base       = '0;
        end
    endgenerate

    // Stage 2: all outputs come straight from these flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            parity    <= 1'b0;
        end else if (adv2) begin
            out_valid <= 1'b1;
            result    <= res_c;
            zero      <= (res_c == '0);
            parity    <= ^res_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
